// File: rtl/alu_result_stage_if.sv
// EX-to-MEM bus of the ALU result stage: EX-side inputs, MEM-side outputs
// and the exception-request handshake with the exception controller.
interface alu_result_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic [DATA_W-1:0] alu_result;
    logic              alu_z;
    logic              alu_v;
    logic              alu_n;
    logic [2:0]        in_op;
    logic              in_trap_en;
    logic [DATA_W-1:0] in_pc;
    logic [RD_W-1:0]   in_rd;
    logic              in_regwrite;
    logic              in_memread;
    logic              in_memwrite;
    logic [DATA_W-1:0] in_store_data;
    logic              stall;
    logic              flush;
    logic              exc_ack;

    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_regwrite;
    logic              out_memread;
    logic              out_memwrite;
    logic [DATA_W-1:0] out_store_data;
    logic              branch_taken;
    logic              exc_req;
    logic [DATA_W-1:0] exc_epc;
    logic              ex_hold;

    modport master (
        output in_valid, alu_result, alu_z, alu_v, alu_n, in_op, in_trap_en, in_pc,
               in_rd, in_regwrite, in_memread, in_memwrite, in_store_data,
               stall, flush, exc_ack,
        input  out_valid, out_result, out_rd, out_regwrite, out_memread, out_memwrite,
               out_store_data, branch_taken, exc_req, exc_epc, ex_hold
    );

    modport slave (
        input  in_valid, alu_result, alu_z, alu_v, alu_n, in_op, in_trap_en, in_pc,
               in_rd, in_regwrite, in_memread, in_memwrite, in_store_data,
               stall, flush, exc_ack,
        output out_valid, out_result, out_rd, out_regwrite, out_memread, out_memwrite,
               out_store_data, branch_taken, exc_req, exc_epc, ex_hold
    );
endinterface

// File: rtl/alu_result_stage.sv
// EX/MEM register behind the add/sub ALU: resolves SLT/branch results from the
// Z/V/N flags and raises a held overflow-exception request until acknowledged.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input logic              clk,
    input logic              reset,
    alu_result_stage_if.slave bus
);
    typedef enum logic [2:0] {
        OP_PASS = 3'd0, OP_SLT  = 3'd1, OP_BEQ  = 3'd2, OP_BNE  = 3'd3,
        OP_BLTZ = 3'd4, OP_BGEZ = 3'd5, OP_BLEZ = 3'd6, OP_BGTZ = 3'd7
    } op_e;

    logic              valid_q, regwrite_q, memread_q, memwrite_q, taken_q, exc_req_q;
    logic [DATA_W-1:0] result_q, store_q, epc_q;
    logic [RD_W-1:0]   rd_q;

    logic              taken_d;
    logic [DATA_W-1:0] result_d;
    logic              load, accept, ovf;

    always_comb begin
        taken_d  = 1'b0;
        result_d = bus.alu_result;
        case (op_e'(bus.in_op))
            OP_SLT:  result_d = {{(DATA_W-1){1'b0}}, bus.alu_n};
            OP_BEQ:  taken_d  = bus.alu_z;
            OP_BNE:  taken_d  = ~bus.alu_z;
            OP_BLTZ: taken_d  = bus.alu_n;
            OP_BGEZ: taken_d  = ~bus.alu_n;
            OP_BLEZ: taken_d  = bus.alu_n | bus.alu_z;
            OP_BGTZ: taken_d  = ~bus.alu_n & ~bus.alu_z;
            default: taken_d  = 1'b0;
        endcase
    end

    // A pending exception (including its ack cycle) forces bubbles into the stage.
    assign load   = ~bus.flush & ~bus.stall;
    assign accept = load & bus.in_valid & ~exc_req_q;
    assign ovf    = accept & bus.in_trap_en & bus.alu_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            taken_q    <= 1'b0;
            exc_req_q  <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            epc_q      <= '0;
            rd_q       <= '0;
        end else begin
            if (exc_req_q) begin
                if (bus.exc_ack) exc_req_q <= 1'b0;
            end else if (ovf) begin
                exc_req_q <= 1'b1;
                epc_q     <= bus.in_pc;
            end

            if (bus.flush || load) begin
                valid_q    <= accept & ~ovf;
                regwrite_q <= accept & ~ovf & bus.in_regwrite;
                memread_q  <= accept & ~ovf & bus.in_memread;
                memwrite_q <= accept & ~ovf & bus.in_memwrite;
                taken_q    <= accept & ~ovf & taken_d;
            end
            if (load) begin
                result_q <= result_d;
                store_q  <= bus.in_store_data;
                rd_q     <= bus.in_rd;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_result     = result_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_regwrite   = regwrite_q;
    assign bus.out_memread    = memread_q;
    assign bus.out_memwrite   = memwrite_q;
    assign bus.out_store_data = store_q;
    assign bus.branch_taken   = taken_q;
    assign bus.exc_req        = exc_req_q;
    assign bus.exc_epc        = epc_q;
    assign bus.ex_hold        = exc_req_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: hand-computed vectors checked with
// immediate assertions one cycle after each load edge.
module tb_alu_result_stage;
    logic clk;
    logic reset;
    int   passes = 0;
    int   total  = 0;

    alu_result_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

    alu_result_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.alu_result    = '0;
        bus.alu_z         = 1'b0;
        bus.alu_v         = 1'b0;
        bus.alu_n         = 1'b0;
        bus.in_op         = 3'd0;
        bus.in_trap_en    = 1'b0;
        bus.in_pc         = '0;
        bus.in_rd         = '0;
        bus.in_regwrite   = 1'b0;
        bus.in_memread    = 1'b0;
        bus.in_memwrite   = 1'b0;
        bus.in_store_data = '0;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.exc_ack       = 1'b0;
    endtask

    task automatic instr(input logic [2:0] op, input logic [31:0] res,
                         input logic z, input logic n, input logic v, input logic trap,
                         input logic [31:0] pc, input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.alu_result  = res;
        bus.alu_z       = z;
        bus.alu_n       = n;
        bus.alu_v       = v;
        bus.in_trap_en  = trap;
        bus.in_pc       = pc;
        bus.in_rd       = rd;
        bus.in_regwrite = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.alu_result = $urandom; bus.in_pc = $urandom;
        bus.alu_v = 1'b1; bus.in_trap_en = 1'b1; bus.in_regwrite = 1'b1;
        bus.in_op = 3'($urandom_range(0, 7)); bus.exc_ack = 1'b1;
        tick(); tick();
        chk("rst_valid",  {31'b0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_rd",     {27'b0, bus.out_rd}, 32'd0);
        chk("rst_ctrl",   {29'b0, bus.out_regwrite, bus.out_memread, bus.out_memwrite}, 32'd0);
        chk("rst_store",  bus.out_store_data, 32'd0);
        chk("rst_taken",  {31'b0, bus.branch_taken}, 32'd0);
        chk("rst_exc",    {31'b0, bus.exc_req}, 32'd0);
        chk("rst_epc",    bus.exc_epc, 32'd0);
        chk("rst_hold",   {31'b0, bus.ex_hold}, 32'd0);
        reset = 1'b0;
        idle();

        // PASS with store data and memwrite
        instr(3'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 5'd5);
        bus.in_memwrite = 1'b1; bus.in_store_data = 32'hDEAD_BEEF;
        tick();
        chk("pass_result", bus.out_result, 32'h0000_1234);
        chk("pass_rd",     {27'b0, bus.out_rd}, 32'd5);
        chk("pass_rw",     {31'b0, bus.out_regwrite}, 32'd1);
        chk("pass_valid",  {31'b0, bus.out_valid}, 32'd1);
        chk("pass_mw",     {31'b0, bus.out_memwrite}, 32'd1);
        chk("pass_store",  bus.out_store_data, 32'hDEAD_BEEF);
        idle();

        // SLT both polarities
        instr(3'd1, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd6);
        tick();
        chk("slt_n1", bus.out_result, 32'h0000_0001);
        bus.alu_n = 1'b0;
        tick();
        chk("slt_n0", bus.out_result, 32'h0000_0000);

        // Branches
        instr(3'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        tick();
        chk("beq_z1", {31'b0, bus.branch_taken}, 32'd1);
        instr(3'd7, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        tick();
        chk("bgtz_z1", {31'b0, bus.branch_taken}, 32'd0);
        instr(3'd3, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        tick();
        chk("bne_z0", {31'b0, bus.branch_taken}, 32'd1);
        instr(3'd6, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        tick();
        chk("blez_n1", {31'b0, bus.branch_taken}, 32'd1);

        // Stall holds branch_taken against an input that would clear it
        instr(3'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_taken", {31'b0, bus.branch_taken}, 32'd1);
        end
        chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.stall = 1'b0;
        tick();
        chk("unstall_taken", {31'b0, bus.branch_taken}, 32'd0);

        // invalid slot loads a bubble
        idle();
        tick();
        chk("bubble_valid", {31'b0, bus.out_valid}, 32'd0);

        // Overflow trap (0x7FFFFFFF + 1)
        instr(3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0020, 5'd7);
        tick();
        chk("ovf_req",   {31'b0, bus.exc_req}, 32'd1);
        chk("ovf_epc",   bus.exc_epc, 32'h0040_0020);
        chk("ovf_rw",    {31'b0, bus.out_regwrite}, 32'd0);
        chk("ovf_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ovf_hold",  {31'b0, bus.ex_hold}, 32'd1);
        instr(3'd0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0024, 5'd8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pend_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("pend_req",   {31'b0, bus.exc_req}, 32'd1);
        end
        chk("pend_epc", bus.exc_epc, 32'h0040_0020);
        // ack cycle: a second overflow must be ignored
        instr(3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0099, 5'd9);
        bus.exc_ack = 1'b1;
        tick();
        chk("ack_req",   {31'b0, bus.exc_req}, 32'd0);
        chk("ack_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ack_epc",   bus.exc_epc, 32'h0040_0020);
        idle();
        instr(3'd0, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0028, 5'd3);
        tick();
        chk("resume_valid",  {31'b0, bus.out_valid}, 32'd1);
        chk("resume_result", bus.out_result, 32'h0000_ABCD);
        chk("resume_req",    {31'b0, bus.exc_req}, 32'd0);

        // Flush beats overflow
        instr(3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0030, 5'd7);
        bus.flush = 1'b1;
        tick();
        chk("flush_req",   {31'b0, bus.exc_req}, 32'd0);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_rw",    {31'b0, bus.out_regwrite}, 32'd0);
        bus.flush = 1'b0;

        // addu: overflow without trap enable writes normally
        bus.in_trap_en = 1'b0;
        tick();
        chk("addu_valid",  {31'b0, bus.out_valid}, 32'd1);
        chk("addu_result", bus.out_result, 32'h8000_0000);
        chk("addu_rw",     {31'b0, bus.out_regwrite}, 32'd1);
        chk("addu_req",    {31'b0, bus.exc_req}, 32'd0);

        // Overflow under stall is deferred to the load edge
        instr(3'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 5'd7);
        bus.stall = 1'b1;
        tick();
        chk("stall_ovf_req", {31'b0, bus.exc_req}, 32'd0);
        bus.stall = 1'b0;
        tick();
        chk("load_ovf_req", {31'b0, bus.exc_req}, 32'd1);
        chk("load_ovf_epc", bus.exc_epc, 32'h0040_0040);

        // Reset clears a pending request without ack
        idle();
        reset = 1'b1;
        tick();
        chk("rst_pend_req", {31'b0, bus.exc_req}, 32'd0);
        chk("rst_pend_epc", bus.exc_epc, 32'd0);
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
